// File: rtl/axi_lite_master.sv
// axi_lite_master: AXI4-Lite initiator behind a single-outstanding core
// request port. One read or write is accepted in IDLE and carried through
// the full AXI-Lite handshake. Completion is signalled by a one-cycle
// req_ready pulse carrying the response code and, for reads, the data.
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,

  // Core request port
  input  logic                              req_valid,
  input  logic                              req_wen,
  input  logic                              req_ren,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   req_wmask,
  output logic                              req_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     req_rdata,
  output logic [1:0]                        req_resp,
  output logic                              req_busy,

  // Write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,

  // Write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,

  // Write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,

  // Read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,

  // Read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_e;

  state_e          state_q;

  // Latched request; drives the AXI payload for the whole transaction so
  // address/data stay stable while the corresponding VALID is high.
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;

  // Registered channel handshake outputs
  logic            awvalid_q;
  logic            wvalid_q;
  logic            bready_q;
  logic            arvalid_q;
  logic            rready_q;

  // Per-channel completion flags for the independent AW and W channels
  logic            aw_done_q;
  logic            w_done_q;
  logic            aw_done_d;
  logic            w_done_d;

  // Core-side results
  logic            req_ready_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      resp_q;

  // Fold a handshake happening this cycle into the done flags, so a write
  // can leave WRITE in the same cycle its last channel completes.
  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & M_AXI_AWREADY);
    w_done_d  = w_done_q  | (wvalid_q  & M_AXI_WREADY);
  end

  // Transaction sequencer: state, latched request, handshake outputs, results.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking '=' would let later lines see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
    end else begin
      // Completion is a pulse: only the entry into DONE raises it.
      req_ready_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (req_valid && (req_wen || req_ren)) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wmask;
            if (req_wen) begin
              // Write wins when both request bits are set.
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_RADDR;
            end
          end
        end

        S_WRITE: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d) begin
            awvalid_q <= 1'b0;
          end
          if (w_done_d) begin
            wvalid_q <= 1'b0;
          end
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (M_AXI_BVALID) begin
            resp_q      <= M_AXI_BRESP;
            bready_q    <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_RADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (M_AXI_RVALID) begin
            rdata_q     <= M_AXI_RDATA;
            resp_q      <= M_AXI_RRESP;
            rready_q    <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Core-side outputs
  assign req_ready     = req_ready_q;
  assign req_rdata     = rdata_q;
  assign req_resp      = resp_q;
  assign req_busy      = (state_q != S_IDLE);

  // AXI outputs: payload from the latched request, protection fixed to
  // unprivileged/secure/data.
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a behavioural AXI-Lite memory slave with
// programmable per-channel stalls and response codes, plus a reference
// model (byte-masked memory, expected latency from the stall settings)
// that every completed request is checked against.
module tb_axi_lite_master;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          req_valid = 1'b0;
  logic          req_wen   = 1'b0;
  logic          req_ren   = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wmask = '0;
  logic          req_ready;
  logic [DW-1:0] req_rdata;
  logic [1:0]    req_resp;
  logic          req_busy;

  logic [AW-1:0] m_awaddr;
  logic [2:0]    m_awprot;
  logic          m_awvalid;
  logic          m_awready = 1'b0;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wvalid;
  logic          m_wready  = 1'b0;
  logic [1:0]    m_bresp   = 2'b00;
  logic          m_bvalid  = 1'b0;
  logic          m_bready;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arprot;
  logic          m_arvalid;
  logic          m_arready = 1'b0;
  logic [DW-1:0] m_rdata   = '0;
  logic [1:0]    m_rresp   = 2'b00;
  logic          m_rvalid  = 1'b0;
  logic          m_rready;

  always #5 clk = ~clk;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH (DW),
    .C_M_AXI_ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_wen       (req_wen),
    .req_ren       (req_ren),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wmask     (req_wmask),
    .req_ready     (req_ready),
    .req_rdata     (req_rdata),
    .req_resp      (req_resp),
    .req_busy      (req_busy),
    .M_AXI_AWADDR  (m_awaddr),
    .M_AXI_AWPROT  (m_awprot),
    .M_AXI_AWVALID (m_awvalid),
    .M_AXI_AWREADY (m_awready),
    .M_AXI_WDATA   (m_wdata),
    .M_AXI_WSTRB   (m_wstrb),
    .M_AXI_WVALID  (m_wvalid),
    .M_AXI_WREADY  (m_wready),
    .M_AXI_BRESP   (m_bresp),
    .M_AXI_BVALID  (m_bvalid),
    .M_AXI_BREADY  (m_bready),
    .M_AXI_ARADDR  (m_araddr),
    .M_AXI_ARPROT  (m_arprot),
    .M_AXI_ARVALID (m_arvalid),
    .M_AXI_ARREADY (m_arready),
    .M_AXI_RDATA   (m_rdata),
    .M_AXI_RRESP   (m_rresp),
    .M_AXI_RVALID  (m_rvalid),
    .M_AXI_RREADY  (m_rready)
  );

  // ---------------- slave knobs, written by the stimulus ----------------
  int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  // ---------------- slave state and observations ----------------
  bit            aw_got = 0, w_got = 0, ar_got = 0, b_commit = 0, r_commit = 0;
  int            aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [DW-1:0] s_wdata = '0, s_word = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic [DW-1:0] smem [logic [AW-1:0]];
  int            n_aw = 0, n_ar = 0, n_ready = 0, proto_viol = 0;
  bit            p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0, p_arv = 0, p_arhs = 0;
  logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic [SW-1:0] p_wstrb = '0;

  // Slave: samples DUT outputs and drives its own signals on the falling
  // edge; a VALID&&READY pair seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0;
      aw_got = 0; w_got = 0; ar_got = 0; b_commit = 0; r_commit = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      // A VALID left without handshake must persist with unchanged payload.
      if (p_awv && !p_awhs && (!m_awvalid || m_awaddr !== p_awaddr)) proto_viol++;
      if (p_wv && !p_whs && (!m_wvalid || m_wdata !== p_wdata || m_wstrb !== p_wstrb)) proto_viol++;
      if (p_arv && !p_arhs && (!m_arvalid || m_araddr !== p_araddr)) proto_viol++;
      if (req_ready) n_ready++;

      // Write response: memory updated once both AW and W have arrived.
      if (b_commit) begin m_bvalid = 1'b0; b_commit = 0; end
      if (aw_got && w_got && !m_bvalid) begin
        if (b_wait >= b_dly) begin
          s_word = smem.exists(s_awaddr) ? smem[s_awaddr] : '0;
          for (int i = 0; i < SW; i++)
            if (s_wstrb[i]) s_word[8*i +: 8] = s_wdata[8*i +: 8];
          smem[s_awaddr] = s_word;
          m_bvalid = 1'b1; m_bresp = bresp_cfg;
          aw_got = 0; w_got = 0; b_wait = 0;
        end else b_wait++;
      end
      if (m_bvalid && m_bready) b_commit = 1;

      m_awready = 1'b0;
      if (m_awvalid && !aw_got) begin
        if (aw_wait >= aw_dly) begin
          m_awready = 1'b1; aw_got = 1; s_awaddr = m_awaddr; aw_wait = 0; n_aw++;
        end else aw_wait++;
      end
      m_wready = 1'b0;
      if (m_wvalid && !w_got) begin
        if (w_wait >= w_dly) begin
          m_wready = 1'b1; w_got = 1; s_wdata = m_wdata; s_wstrb = m_wstrb; w_wait = 0;
        end else w_wait++;
      end

      // Read data
      if (r_commit) begin m_rvalid = 1'b0; r_commit = 0; end
      if (ar_got && !m_rvalid) begin
        if (r_wait >= r_dly) begin
          m_rvalid = 1'b1;
          m_rdata  = smem.exists(s_araddr) ? smem[s_araddr] : '0;
          m_rresp  = rresp_cfg;
          ar_got = 0; r_wait = 0;
        end else r_wait++;
      end
      if (m_rvalid && m_rready) r_commit = 1;

      m_arready = 1'b0;
      if (m_arvalid && !ar_got) begin
        if (ar_wait >= ar_dly) begin
          m_arready = 1'b1; ar_got = 1; s_araddr = m_araddr; ar_wait = 0; n_ar++;
        end else ar_wait++;
      end

      p_awv = m_awvalid; p_awhs = m_awvalid && m_awready; p_awaddr = m_awaddr;
      p_wv  = m_wvalid;  p_whs  = m_wvalid && m_wready;   p_wdata = m_wdata; p_wstrb = m_wstrb;
      p_arv = m_arvalid; p_arhs = m_arvalid && m_arready; p_araddr = m_araddr;
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_last = '0;
  int            exp_ready = 0;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] m);
    logic [DW-1:0] w;
    w = ref_read(a);
    for (int i = 0; i < SW; i++)
      if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[a] = w;
  endtask

  // Per-transaction observations, for test-specific checks.
  int aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, first_b, last_w, wbad;

  // Issue one request and follow it to completion (or to a reset at cycle
  // rst_at). Latency, data and response are checked against the model.
  task automatic run_req(input string tag, input bit wen, input bit ren,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wmask, input int rst_at, input bit poke);
    int            exp_cyc;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    bit            done;
    bit            aborted;
    int            cyc;
    logic [DW-1:0] got_rdata;
    logic [1:0]    got_resp;

    if (wen) begin
      exp_cyc   = ((aw_dly > w_dly) ? aw_dly : w_dly) + 3 + b_dly;
      exp_rdata = ref_last;
      exp_resp  = bresp_cfg;
    end else begin
      exp_cyc   = ar_dly + 3 + r_dly;
      exp_rdata = ref_read(addr);
      exp_resp  = rresp_cfg;
    end

    aw_cyc = 0; w_cyc = 0; b_cyc = 0; ar_cyc = 0; r_cyc = 0;
    first_b = 0; last_w = 0; wbad = 0;
    done = 0; aborted = 0; cyc = 0; got_rdata = '0; got_resp = 2'b00;

    req_valid = 1'b1; req_wen = wen; req_ren = ren;
    req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    tick();
    // Scramble the request inputs so only the latched copy can be correct.
    req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0;
    req_addr = ~addr; req_wdata = ~wdata; req_wmask = ~wmask;

    for (int k = 1; k <= 200 && !done; k++) begin
      if (m_awvalid) aw_cyc++;
      if (m_wvalid) begin
        w_cyc++; last_w = k;
        if (m_wdata !== wdata || m_wstrb !== wmask) wbad++;
      end
      if (m_bready) begin b_cyc++; if (first_b == 0) first_b = k; end
      if (m_arvalid) ar_cyc++;
      if (m_rready) r_cyc++;
      if (poke && k == 1) begin req_valid = 1'b1; req_wen = 1'b1; req_ren = 1'b1; end
      if (poke && k == 2) begin req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0; end

      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        aborted = 1; done = 1;
      end else if (req_ready) begin
        done = 1; cyc = k; got_rdata = req_rdata; got_resp = req_resp;
      end else begin
        tick();
      end
    end
    check_int({tag, "_finished"}, int'(done), 1);

    if (aborted) begin
      ref_last = '0;
    end else if (done) begin
      exp_ready++;
      check_int({tag, "_latency"}, cyc, exp_cyc);
      check({tag, "_rdata"}, got_rdata, exp_rdata);
      check({tag, "_resp"}, 64'(got_resp), 64'(exp_resp));
      if (wen) ref_write(addr, wdata, wmask);
      else     ref_last = exp_rdata;
      tick();
      check_int({tag, "_one_pulse_idle"}, int'({req_ready, req_busy}), 0);
    end
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int snap;
    logic [DW-1:0] d;

    rst = 1'b1;
    tick(); tick(); tick();
    check_int("reset_axi_ctrl",
              int'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 0);
    check_int("reset_core_ctrl", int'({req_ready, req_busy}), 0);
    check("reset_rdata", req_rdata, '0);
    check("reset_resp", 64'(req_resp), 64'(0));
    rst = 1'b0;
    tick();

    // A strobe with neither request bit set is ignored.
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_int("ignored_busy", int'(req_busy), 0);
    tick();
    check_int("ignored_no_axi", n_aw + n_ar, 0);

    // Zero-wait write
    run_req("wr0", 1, 0, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0);
    check_int("wr0_aw_cycles", aw_cyc, 1);
    check_int("wr0_w_cycles", w_cyc, 1);
    check_int("wr0_b_cycles", b_cyc, 1);
    check("wr0_awaddr", s_awaddr, 64'h10);
    check("wr0_wstrb", 64'(s_wstrb), 64'hFF);
    check("wr0_wdata", s_wdata, 64'hDEADBEEF_CAFEF00D);
    check_int("wr0_prot", int'({m_awprot, m_arprot}), 0);

    // Zero-wait read back of the same word
    run_req("rd0", 0, 1, 64'h10, '0, '0, 0, 0);
    check_int("rd0_ar_cycles", ar_cyc, 1);
    check_int("rd0_r_cycles", r_cyc, 1);
    check("rd0_value", req_rdata, 64'hDEADBEEF_CAFEF00D);

    // Skewed channels: W stalled three cycles, AW immediate
    w_dly = 3;
    run_req("skew", 1, 0, 64'h18, 64'h0123_4567_89AB_CDEF, 8'h0F, 0, 0);
    check_int("skew_aw_cycles", aw_cyc, 1);
    check_int("skew_w_cycles", w_cyc, 4);
    check_int("skew_bready_after_w", first_b, last_w + 1);
    check_int("skew_wdata_stable", wbad, 0);
    w_dly = 0;

    // Stalled AR with SLVERR, plus a stray request during the transaction
    ar_dly = 2; rresp_cfg = 2'b10;
    snap = n_aw;
    run_req("err", 0, 1, 64'h18, '0, '0, 0, 1);
    check_int("err_ar_cycles", ar_cyc, 3);
    tick(); tick();
    check_int("err_stray_ignored", n_aw - snap, 0);
    check_int("err_stays_idle", int'(req_busy), 0);
    ar_dly = 0; rresp_cfg = 2'b00;

    // Both request bits: write only
    snap = n_ar;
    run_req("both", 1, 1, 64'h20, 64'hA5A5_5A5A_F00F_0FF0, 8'hC3, 0, 0);
    check_int("both_aw_cycles", aw_cyc, 1);
    check_int("both_no_ar", ar_cyc + (n_ar - snap), 0);

    // Reset while waiting in WRESP
    b_dly = 5;
    snap = n_ready;
    run_req("rstw", 1, 0, 64'h28, 64'h1111_2222_3333_4444, 8'hFF, 3, 0);
    check_int("rstw_abort_outputs", int'({m_bready, req_busy, req_ready}), 0);
    tick(); tick(); tick();
    check_int("rstw_no_ready", n_ready - snap, 0);
    check("rstw_rdata_cleared", req_rdata, '0);
    b_dly = 0;
    run_req("post_rst_rd", 0, 1, 64'h10, '0, '0, 0, 0);

    // Randomized traffic over a small address window
    for (int t = 0; t < 24; t++) begin
      bit w;
      logic [AW-1:0] a;
      w  = 1'($urandom_range(0, 1));
      a  = 64'h100 + 64'(8 * $urandom_range(0, 7));
      d  = {$urandom, $urandom};
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      run_req($sformatf("rnd%0d", t), w, !w || (($urandom & 1) == 1), a, d, 8'($urandom), 0, 0);
    end

    tick();
    check_int("protocol_violations", proto_viol, 0);
    check_int("completion_pulses", n_ready, exp_ready);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
